cpu_datapath: RTL and testbench
===============================

// Module: cpu_datapath
// PURPOSE
//  Registers, bus, ALU and fetch/execute sequencer of the nic8 CPU, directly downstream of the
//  combinational control decoder. Holds IR and presents it to the decoder; consumes the 14-bit
//  control word; returns aIsZero/flagCarry to the decoder; drives the single-port memory and the
//  output port. Every instruction takes 2 cycles: FETCH then EXEC.
// PARAMETERS
//  RESET_PC   8'h00  PC value after reset.
//  CHECK_BUS  1      1: raise sticky err when EXEC source field is not exactly one-hot.
// PORTS
//  clk        in   1   single clock; all state on posedge.
//  reset_n    in   1   synchronous, active-low reset.
//  ir         out  8   instruction register, feeds the decoder.
//  control    in   14  {loadIR,loadPC,loadA,loadB,loadX,doOut,storeMem,assertM,assertE,
//                       assertA,assertX,immediate,doSubtract,doJump}; bit13 = loadIR.
//  aIsZero    out  1   combinational (A == 0).
//  flagCarry  out  1   registered ALU carry flag.
//  mem_addr   out  8   memory address.
//  mem_rdata  in   8   combinational (same-cycle) read data at mem_addr.
//  mem_wdata  out  8   write data (= bus).
//  mem_we     out  1   write strobe, sampled by memory on posedge.
//  out_data   out  8   output port register.
//  out_valid  out  1   one-cycle pulse when out_data is loaded.
//  err        out  1   sticky bus-contention flag.
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): PC=RESET_PC; IR=A=B=X=out_data=8'h00; flagCarry=0; out_valid=0;
//   err=0; state=FETCH. mem_we is 0 whenever reset_n=0. Reset wins over any in-flight EXEC.
//  FETCH: mem_addr=PC; mem_we=0; IR<=mem_rdata; PC<=PC+1 (8-bit wrap, FF->00); next EXEC.
//   control ignored in FETCH.
//  EXEC: mem_addr = immediate ? PC : X.
//   bus = assertM ? mem_rdata : assertE ? alu : assertA ? A : assertX ? X : 8'h00.
//   alu: {cout,alu} = doSubtract ? A + ~B + 1 : A + B (9-bit; cout=1 on sub means no borrow).
//   flagCarry <= cout on every EXEC with assertE=1; otherwise holds.
//   loadA/loadB/loadX: register <= bus. Multiple loads in one cycle all take effect.
//   storeMem: mem_we=1, mem_wdata=bus, same cycle; memory written at mem_addr.
//   doOut: out_data<=bus; out_valid=1 for the following cycle only.
//   PC: doJump ? PC<=bus : immediate ? PC<=PC+1 : hold. loadPC with doJump=0 = untaken
//    branch; the operand is still skipped when immediate=1.
//   next state: loadIR ? stay EXEC with IR<=bus (chained instruction, no fetch) : FETCH.
//  Flags are sampled by the decoder from current-cycle registers. A jump using flags sees the
//   values left by earlier instructions, never the same-cycle ALU result.
//  err: in EXEC with CHECK_BUS=1, err<=1 if popcount(assertM..assertX)!=1; cleared only by reset.
//  Boundaries: PC wraps FF->00 in both states. X-indexed store to 8'hFF is legal. Store with
//   assertM reads and writes the same address in the same cycle: the old value is written back.
//  Synthesis: no latches; outputs in FETCH are fully defined.
// TESTING
//  1 Reset: hold reset_n=0 two cycles mid-EXEC of a store -> mem_we=0, PC=00, state FETCH, all regs 0.
//  2 Load-imm/add: mem[0..3]={A<-imm,05,B<-imm,03}, then A<-E add -> A=08, flagCarry=0, PC=05.
//  3 Subtract carry: A=03,B=05, A<-E sub -> A=FE, flagCarry=0.
//    A=05,B=03 -> A=02, flagCarry=1.
//  4 Jumps: A=00, jump-if-zero imm 40 -> PC=40.
//    A=01, same instruction -> PC=PC+1 (operand skipped), no jump.
//  5 Indexed store/out: X=FF, store A(=5A) indexed -> mem[FF]=5A, mem_we high one cycle.
//    out A -> out_data=5A, out_valid pulse exactly 1 cycle.
//  6 Wrap and err: PC=FF in FETCH -> PC=00.
//    Force control with assertM and assertA both set in EXEC -> err=1, stays 1 until reset.

Source files
------------

// File: rtl/cpu_datapath.sv
`default_nettype none
// ============================================================================
// Module   : cpu_datapath
// Purpose  : nic8 registers, bus, ALU and two-phase FETCH/EXEC sequencer.
// Revision : 1.0  initial release
// ============================================================================
module cpu_datapath #(
  parameter logic [7:0] RESET_PC  = 8'h00,
  parameter bit         CHECK_BUS = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [7:0]  ir,
  input  logic [13:0] control,
  output logic        aIsZero,
  output logic        flagCarry,
  output logic [7:0]  mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        err
);

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_EXEC  = 1'b1
  } state_t;

  state_t     r_state;
  logic [7:0] r_pc, r_ir, r_a, r_b, r_x, r_out;
  logic       r_carry, r_out_valid, r_err;

  logic       w_load_ir, w_load_a, w_load_b, w_load_x, w_do_out, w_store;
  logic       w_assert_m, w_assert_e, w_assert_a, w_assert_x;
  logic       w_imm, w_do_sub, w_do_jump, w_unused_load_pc;
  logic       w_exec, w_bus_bad;
  logic [7:0] w_bus, w_pc_inc;
  logic [8:0] w_sum;

  assign w_load_ir        = control[13];
  assign w_unused_load_pc = control[12];  // PC update is fully decided by doJump/immediate
  assign w_load_a         = control[11];
  assign w_load_b         = control[10];
  assign w_load_x         = control[9];
  assign w_do_out         = control[8];
  assign w_store          = control[7];
  assign w_assert_m       = control[6];
  assign w_assert_e       = control[5];
  assign w_assert_a       = control[4];
  assign w_assert_x       = control[3];
  assign w_imm            = control[2];
  assign w_do_sub         = control[1];
  assign w_do_jump        = control[0];

  assign w_exec    = (r_state == S_EXEC);
  assign w_pc_inc  = r_pc + 8'd1;
  assign w_bus_bad = ($countones(control[6:3]) != 1);

  // Subtract as A + ~B + 1 so carry-out means "no borrow".
  assign w_sum = w_do_sub ? ({1'b0, r_a} + {1'b0, ~r_b} + 9'd1)
                          : ({1'b0, r_a} + {1'b0, r_b});

  always_comb begin
    w_bus = 8'h00;
    if (w_exec) begin
      if (w_assert_m)      w_bus = mem_rdata;
      else if (w_assert_e) w_bus = w_sum[7:0];
      else if (w_assert_a) w_bus = r_a;
      else if (w_assert_x) w_bus = r_x;
    end
  end

  assign mem_addr  = (w_exec && !w_imm) ? r_x : r_pc;
  assign mem_wdata = w_bus;
  assign mem_we    = reset_n && w_exec && w_store;
  assign ir        = r_ir;
  assign aIsZero   = (r_a == 8'h00);
  assign flagCarry = r_carry;
  assign out_data  = r_out;
  assign out_valid = r_out_valid;
  assign err       = r_err;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_PC;
      r_ir        <= 8'h00;
      r_a         <= 8'h00;
      r_b         <= 8'h00;
      r_x         <= 8'h00;
      r_out       <= 8'h00;
      r_carry     <= 1'b0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_FETCH: begin
          r_ir    <= mem_rdata;
          r_pc    <= w_pc_inc;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (w_load_a) r_a <= w_bus;
          if (w_load_b) r_b <= w_bus;
          if (w_load_x) r_x <= w_bus;
          if (w_do_out) begin
            r_out       <= w_bus;
            r_out_valid <= 1'b1;
          end
          if (w_assert_e) r_carry <= w_sum[8];
          if (w_do_jump)  r_pc <= w_bus;
          else if (w_imm) r_pc <= w_pc_inc;
          if (CHECK_BUS && w_bus_bad) r_err <= 1'b1;
          // loadIR chains straight into the next instruction without a fetch.
          if (w_load_ir) r_ir <= w_bus;
          else           r_state <= S_FETCH;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_datapath
// Purpose  : Directed-vector bench for cpu_datapath with instruction-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_cpu_datapath;

  localparam logic [13:0] C_LIR = 14'h2000, C_LPC = 14'h1000, C_LA  = 14'h0800;
  localparam logic [13:0] C_LB  = 14'h0400, C_LX  = 14'h0200, C_OUT = 14'h0100;
  localparam logic [13:0] C_ST  = 14'h0080, C_AM  = 14'h0040, C_AE  = 14'h0020;
  localparam logic [13:0] C_AA  = 14'h0010, C_IMM = 14'h0004, C_SUB = 14'h0002;
  localparam logic [13:0] C_JMP = 14'h0001;

  localparam logic [13:0] I_LDA = C_LA | C_AM | C_IMM;
  localparam logic [13:0] I_LDB = C_LB | C_AM | C_IMM;
  localparam logic [13:0] I_LDX = C_LX | C_AM | C_IMM;
  localparam logic [13:0] I_ADD = C_LA | C_AE;
  localparam logic [13:0] I_SUB = C_LA | C_AE | C_SUB;
  localparam logic [13:0] I_STX = C_ST | C_AA;
  localparam logic [13:0] I_OUT = C_OUT | C_AA;
  localparam logic [13:0] I_JZ  = C_LPC | C_AM | C_IMM;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [13:0] control;
  logic [7:0]  ir, mem_addr, mem_rdata, mem_wdata, out_data;
  logic        aIsZero, flagCarry, mem_we, out_valid, err;

  logic [7:0]  m  [256];
  logic [7:0]  mm [256];
  int          n_chk = 0;
  int          n_bad = 0;
  int          we_cnt = 0;
  int          we_mark;
  logic        chk_en = 1'b0;

  logic [7:0]  e_pc, e_ir, e_a, e_b, e_x, e_out;
  logic        e_c, e_ov, e_err, e_exec;

  cpu_datapath #(.RESET_PC(8'h00), .CHECK_BUS(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .ir(ir), .control(control),
    .aIsZero(aIsZero), .flagCarry(flagCarry), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .out_data(out_data), .out_valid(out_valid), .err(err)
  );

  always #5 clk = ~clk;

  assign mem_rdata = m[mem_addr];
  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      m[mem_addr] <= mem_wdata;
      we_cnt      <= we_cnt + 1;
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: architectural effect of the control word on the programmer-visible state.
  function automatic logic [7:0] f_addr();
    return (e_exec && !control[2]) ? e_x : e_pc;
  endfunction

  function automatic logic [7:0] f_alu();
    logic [7:0] r;
    r = control[1] ? (e_a - e_b) : (e_a + e_b);
    return r;
  endfunction

  function automatic logic f_cout();
    if (control[1]) return (e_a >= e_b);
    return ((int'(e_a) + int'(e_b)) > 255);
  endfunction

  function automatic logic [7:0] f_bus();
    if (!e_exec)    return 8'h00;
    if (control[6]) return mm[f_addr()];
    if (control[5]) return f_alu();
    if (control[4]) return e_a;
    if (control[3]) return e_x;
    return 8'h00;
  endfunction

  task automatic model_step();
    logic [7:0] bus, addr;
    logic       cout;
    if (!reset_n) begin
      e_pc = 8'h00; e_ir = 8'h00; e_a = 8'h00; e_b = 8'h00; e_x = 8'h00;
      e_out = 8'h00; e_c = 1'b0; e_ov = 1'b0; e_err = 1'b0; e_exec = 1'b0;
    end else if (!e_exec) begin
      e_ir = mm[e_pc];
      e_pc = e_pc + 8'd1;
      e_ov = 1'b0;
      e_exec = 1'b1;
    end else begin
      addr = f_addr();
      bus  = f_bus();
      cout = f_cout();
      if (control[11]) e_a = bus;
      if (control[10]) e_b = bus;
      if (control[9])  e_x = bus;
      e_ov = control[8];
      if (control[8])  e_out = bus;
      if (control[7])  mm[addr] = bus;
      if (control[5])  e_c = cout;
      if ($countones(control[6:3]) != 1) e_err = 1'b1;
      if (control[0])      e_pc = bus;
      else if (control[2]) e_pc = e_pc + 8'd1;
      if (control[13]) e_ir = bus;
      else             e_exec = 1'b0;
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ir",        ir,                  e_ir);
      chk("aIsZero",   {7'b0, aIsZero},     {7'b0, e_a == 8'h00});
      chk("flagCarry", {7'b0, flagCarry},   {7'b0, e_c});
      chk("mem_addr",  mem_addr,            f_addr());
      chk("mem_we",    {7'b0, mem_we},      {7'b0, reset_n && e_exec && control[7]});
      if (reset_n && e_exec && control[7]) chk("mem_wdata", mem_wdata, f_bus());
      chk("out_data",  out_data,            e_out);
      chk("out_valid", {7'b0, out_valid},   {7'b0, e_ov});
      chk("err",       {7'b0, err},         {7'b0, e_err});
    end
  end

  task automatic put(input logic [7:0] a, input logic [7:0] v);
    m[a]  = v;
    mm[a] = v;
  endtask

  task automatic cyc(input logic [13:0] c);
    control = c;
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [13:0] c);
    cyc(14'h0000);
    cyc(c);
  endtask

  task automatic instr_jz();
    cyc(14'h0000);
    cyc(I_JZ | ((e_a == 8'h00) ? C_JMP : 14'h0000));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    control = 14'h0000;
    for (int i = 0; i < 256; i++) put(i[7:0], 8'h00);
    put(8'h00, 8'hA1); put(8'h01, 8'h05); put(8'h02, 8'hA2); put(8'h03, 8'h03);
    put(8'h04, 8'hA3); put(8'h05, 8'hA4);
    put(8'h06, 8'hA1); put(8'h07, 8'h03); put(8'h08, 8'hA2); put(8'h09, 8'h05);
    put(8'h0A, 8'hA5); put(8'h0B, 8'hA1); put(8'h0C, 8'h05); put(8'h0D, 8'hA2);
    put(8'h0E, 8'h03); put(8'h0F, 8'hA5);
    put(8'h10, 8'hA1); put(8'h11, 8'h00); put(8'h12, 8'hA6); put(8'h13, 8'h40);
    put(8'h40, 8'hA1); put(8'h41, 8'h01); put(8'h42, 8'hA6); put(8'h43, 8'h77);
    put(8'h44, 8'hA7); put(8'h45, 8'hFF); put(8'h46, 8'hA1); put(8'h47, 8'h5A);
    put(8'h48, 8'hA8); put(8'h49, 8'hA4); put(8'h4A, 8'hA9); put(8'h4B, 8'hFF);

    @(posedge clk); #1;
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Reset held two cycles in the middle of a store
    cyc(14'h0000);
    reset_n = 1'b0;
    cyc(I_STX);
    cyc(I_STX);
    reset_n = 1'b1;
    control = 14'h0000;
    chk("rst_pc",   mem_addr, 8'h00);
    chk("rst_ir",   ir,       8'h00);
    chk("rst_mem0", m[0],     8'hA1);

    // Load immediates and add
    instr(I_LDA);
    instr(I_LDB);
    instr(I_ADD);
    chk("add_a",     e_a,                8'h08);
    chk("add_pc",    e_pc,               8'h05);
    chk("add_fetch", mem_addr,           8'h05);
    chk("add_c",     {7'b0, flagCarry},  8'h00);
    instr(I_OUT);
    chk("add_out",   out_data,           8'h08);

    // Subtract with and without borrow
    instr(I_LDA); instr(I_LDB); instr(I_SUB);
    chk("sub1_a", e_a,               8'hFE);
    chk("sub1_c", {7'b0, flagCarry}, 8'h00);
    instr(I_LDA); instr(I_LDB); instr(I_SUB);
    chk("sub2_a", e_a,               8'h02);
    chk("sub2_c", {7'b0, flagCarry}, 8'h01);

    // Taken and untaken jump-if-zero
    instr(I_LDA);
    instr_jz();
    chk("jz_taken_pc", e_pc,     8'h40);
    chk("jz_taken_ad", mem_addr, 8'h40);
    instr(I_LDA);
    instr_jz();
    chk("jz_skip_pc",  e_pc,     8'h44);
    chk("jz_skip_ad",  mem_addr, 8'h44);

    // Indexed store to FF and output pulse
    instr(I_LDX);
    instr(I_LDA);
    we_mark = we_cnt;
    instr(I_STX);
    chk("st_we_cnt", 8'(we_cnt - we_mark), 8'h01);
    chk("st_memff",  m[8'hFF],             8'h5A);
    instr(I_OUT);
    chk("out_data",  out_data,             8'h5A);
    chk("out_v1",    {7'b0, out_valid},    8'h01);
    cyc(14'h0000);
    chk("out_v0",    {7'b0, out_valid},    8'h00);

    // Unconditional jump to FF, then wrap on fetch
    cyc(I_JZ | C_JMP);
    chk("wrap_ff", mem_addr, 8'hFF);
    cyc(14'h0000);
    control = I_LDA;
    #1;
    chk("wrap_00", mem_addr, 8'h00);
    cyc(I_LDA);
    chk("wrap_a",  e_a,      8'hA1);

    // Bus contention sets sticky err
    instr(C_AM | C_AA);
    chk("err_set",  {7'b0, err}, 8'h01);
    instr(I_ADD);
    chk("err_hold", {7'b0, err}, 8'h01);
    reset_n = 1'b0;
    cyc(14'h0000);
    reset_n = 1'b1;
    chk("err_clr",  {7'b0, err}, 8'h00);

    // Chained instruction through loadIR
    cyc(14'h0000);
    cyc(C_LIR | C_AM | C_IMM);
    chk("chain_ir", ir,       8'h05);
    chk("chain_ad", mem_addr, 8'h02);
    cyc(I_LDB);
    chk("chain_b",  e_b,      8'hA2);
    instr(I_OUT);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
